car_mode_ctrl: RTL
==================

# car_mode_ctrl

Sequencing controller for the line-following car. It combines the synchronized 3-way track sensors with the ultrasonic distance reading and produces the `mode` command consumed by `motor`. Obstacle stopping has hysteresis; a lost line triggers a bounded search before the car halts. It sits between `sonic_top`/sensor pins and `motor` in the `lab6_advanced` top level.

## Interface

Parameters:
- `START_CYC`, default 100_000_000: IDLE hold after reset, 1 s at 100 MHz.
- `DEB_CYC`, default 50_000: cycles a sensor pattern must be stable before acceptance.
- `LOST_CYC`, default 200_000_000: maximum search time in LOST.
- `CLEAR_CYC`, default 25_000_000: cycles `distance >= GO_CM` must hold to leave OBSTACLE.
- `STOP_CM`, default 20'd15: enter OBSTACLE when `distance < STOP_CM`.
- `GO_CM`, default 20'd20: clear threshold. Must satisfy `GO_CM > STOP_CM`.

Ports:
- `clk`, in, 1: system clock, 100 MHz.
- `rst`, in, 1: reset. Asynchronous, active-high. The clock is `clk`.
- `left_track`, `mid_track`, `right_track`, in, 1 each: raw sensor pins, 1 = line detected. Asynchronous to `clk`.
- `distance`, in, 20: unsigned distance in cm from `sonic_top`. Synchronous to `clk`.
- `mode`, out, 3: motor command. STOP=0, FWD=1, LEFT=2, RIGHT=3, BACK=4.
- `state`, out, 3: FSM state for the display. IDLE=0, FOLLOW=1, OBSTACLE=2, LOST=3, HALT=4.
- `obstacle`, out, 1: high while in OBSTACLE.

## Operation

- Sensors pass through a 2-flop synchronizer, giving `pat = {l,m,r}`.
- Debounce: the counter restarts on any `pat` change. `pat` becomes the accepted `trk` once it has been unchanged for `DEB_CYC` consecutive cycles. `trk` resets to 3'b000.
- Follow map from `trk`:
  - 010, 111, 101 → FWD
  - 100, 110 → LEFT
  - 001, 011 → RIGHT
  - 000 → no line
- `last_dir` register:
  - Updated to the mapped mode each cycle in FOLLOW with a non-zero `trk`.
  - Reset value is FWD.
- FSM transitions:
  - IDLE: `mode` = STOP. After `START_CYC` cycles go to FOLLOW.
  - FOLLOW: `mode` = follow map. If `distance < STOP_CM`, go to OBSTACLE. Else if `trk == 000`, go to LOST.
  - OBSTACLE: `mode` = STOP.
    - The clear counter counts while `distance >= GO_CM` and resets whenever `distance < GO_CM`.
    - When the counter reaches `CLEAR_CYC`, go to FOLLOW.
  - LOST: the LOST timer runs.
    - `mode` = `last_dir` if it is LEFT or RIGHT. `mode` = BACK if `last_dir` is FWD.
    - `trk != 000` → FOLLOW.
    - `distance < STOP_CM` → OBSTACLE.
    - Timer reaches `LOST_CYC` → HALT.
  - HALT: `mode` = STOP. Only `rst` exits HALT.
- Priority within one cycle: obstacle, then line found, then timeout. Obstacle together with a timeout goes to OBSTACLE.
- The LOST timer clears on every entry to LOST. It does not resume after an OBSTACLE.
- Distances between `STOP_CM` and `GO_CM - 1` have no effect in FOLLOW and LOST. In OBSTACLE they reset the clear counter.
- Counters saturate at their terminal value and never wrap.

## Timing

- All outputs are registered and change only on `posedge clk`, or asynchronously on `rst`.
- Reset values: `mode` = 0 (STOP), `state` = 0 (IDLE), `obstacle` = 0. All counters = 0. `trk` = 000. `last_dir` = FWD.
- Sensor pin edge to `trk` update: 2 synchronizer cycles + `DEB_CYC` cycles.
- `trk` or `distance` change to `state`/`mode` change: 1 cycle.
- `mode` and `state` are coherent: both come from the same next-state computation and change on the same edge.
- `rst` asserted mid-operation forces the reset values immediately. The full `START_CYC` hold is repeated after release.

## Test plan

Simulation parameters: `START_CYC`=4, `DEB_CYC`=3, `LOST_CYC`=20, `CLEAR_CYC`=5, `STOP_CM`=15, `GO_CM`=20, `distance`=100 unless stated.

- **Reset/start:** release `rst` with pattern 010. `mode`=0 and `state`=0 for 4 cycles. Then `state`=1. `mode`=1 once `trk` is accepted, i.e. `mode`=1 within 2+3+1 cycles of the pattern appearing.
- **Follow/debounce:** in FOLLOW, apply 100 for 2 cycles, then back to 010. `mode` stays 1. Apply 110 and hold it: `mode`=2 after 2+3+1 cycles. Apply 011 and hold it: `mode`=3.
- **Obstacle hysteresis:** drive `distance` 14. Next cycle `state`=2, `mode`=0, `obstacle`=1. Drive 18 for 10 cycles: stays in OBSTACLE. Drive 20 for 4 cycles then 19: stays. Drive 20 for 5 cycles: `state`=1, `obstacle`=0.
- **Lost recovery:** with `last_dir`=LEFT, apply 000. `state`=3, `mode`=2. Apply 001 before 20 cycles elapse: `state`=1, `mode`=3. Repeat with `last_dir`=FWD: `mode`=4 while in LOST.
- **Lost timeout/simultaneous:** hold 000. After 20 cycles in LOST, `state`=4 and `mode`=0. Later apply 010 and distance changes: HALT persists until `rst`. Separately, drive `distance`=10 on the timeout cycle: `state`=2, not 4.
- **Mid-run reset:** assert `rst` for 1 cycle while in OBSTACLE. Outputs go to 0 asynchronously and the IDLE hold of 4 cycles repeats.

Source files
------------

// File: rtl/car_mode_ctrl.sv
// rtl/car_mode_ctrl.sv - line-following car mode sequencer with obstacle hysteresis and bounded line search
//
// Ports:
//   clk                              system clock
//   rst                              asynchronous active-high reset
//   left_track/mid_track/right_track raw track sensor pins, 1 = line seen (asynchronous)
//   distance[19:0]                   ultrasonic distance in cm (synchronous to clk)
//   mode[2:0]                        motor command: STOP=0 FWD=1 LEFT=2 RIGHT=3 BACK=4
//   state[2:0]                       FSM state: IDLE=0 FOLLOW=1 OBSTACLE=2 LOST=3 HALT=4
//   obstacle                         high while in OBSTACLE

module car_mode_ctrl #(
   parameter int unsigned START_CYC = 100_000_000,
   parameter int unsigned DEB_CYC   = 50_000,
   parameter int unsigned LOST_CYC  = 200_000_000,
   parameter int unsigned CLEAR_CYC = 25_000_000,
   parameter logic [19:0] STOP_CM   = 20'd15,
   parameter logic [19:0] GO_CM     = 20'd20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        left_track,
   input  logic        mid_track,
   input  logic        right_track,
   input  logic [19:0] distance,
   output logic [2:0]  mode,
   output logic [2:0]  state,
   output logic        obstacle
);

   localparam logic [2:0] MODE_STOP  = 3'd0;
   localparam logic [2:0] MODE_FWD   = 3'd1;
   localparam logic [2:0] MODE_LEFT  = 3'd2;
   localparam logic [2:0] MODE_RIGHT = 3'd3;
   localparam logic [2:0] MODE_BACK  = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_FOLLOW   = 3'd1,
      S_OBSTACLE = 3'd2,
      S_LOST     = 3'd3,
      S_HALT     = 3'd4
   } state_t;

   // ---------------------------------------------------------------
   // Sensor synchronizer and debounce
   // ---------------------------------------------------------------
   logic [2:0]  sync1;
   logic [2:0]  pat;
   logic [2:0]  cand;
   logic [31:0] deb_cnt;
   logic [2:0]  trk;

   // deb_cnt counts the cycles pat has matched cand, including the cycle
   // in which the change was first seen, so acceptance lands exactly
   // DEB_CYC cycles after pat settles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1   <= 3'b000;
         pat     <= 3'b000;
         cand    <= 3'b000;
         deb_cnt <= 32'd0;
         trk     <= 3'b000;
      end else begin
         sync1 <= {left_track, mid_track, right_track};
         pat   <= sync1;
         if (pat != cand) begin
            cand    <= pat;
            deb_cnt <= 32'd1;
         end else begin
            if (deb_cnt < DEB_CYC)
               deb_cnt <= deb_cnt + 32'd1;
            if (deb_cnt >= DEB_CYC - 32'd1)
               trk <= cand;
         end
      end
   end

   // ---------------------------------------------------------------
   // Follow map and search direction
   // ---------------------------------------------------------------
   logic [2:0] map_mode;
   logic [2:0] last_dir;
   logic [2:0] lost_mode;

   always_comb begin
      map_mode = MODE_STOP;
      case (trk)
         3'b010, 3'b111, 3'b101: map_mode = MODE_FWD;
         3'b100, 3'b110:         map_mode = MODE_LEFT;
         3'b001, 3'b011:         map_mode = MODE_RIGHT;
         default:                map_mode = MODE_STOP;
      endcase
   end

   // last_dir only ever holds FWD, LEFT or RIGHT; a straight-ahead loss
   // backs up instead of guessing a side.
   always_comb begin
      lost_mode = MODE_BACK;
      if (last_dir == MODE_LEFT || last_dir == MODE_RIGHT)
         lost_mode = last_dir;
   end

   // ---------------------------------------------------------------
   // Sequencing FSM
   // ---------------------------------------------------------------
   state_t      cur_st;
   state_t      nxt_st;
   logic [31:0] tmr;
   logic [31:0] tmr_nxt;
   logic [2:0]  mode_nxt;
   logic        too_near;
   logic        all_clear;

   assign too_near  = (distance < STOP_CM);
   assign all_clear = (distance >= GO_CM);

   // One timer serves the IDLE hold, the OBSTACLE clear window and the
   // LOST search; it is cleared on every state change so each phase
   // starts from zero. Every count stops at its terminal value because
   // reaching that value always leaves the state.
   always_comb begin
      nxt_st  = cur_st;
      tmr_nxt = tmr;
      case (cur_st)
         S_IDLE: begin
            if (tmr >= START_CYC - 32'd1) begin
               nxt_st  = S_FOLLOW;
               tmr_nxt = 32'd0;
            end else begin
               tmr_nxt = tmr + 32'd1;
            end
         end
         S_FOLLOW: begin
            tmr_nxt = 32'd0;
            if (too_near)
               nxt_st = S_OBSTACLE;
            else if (trk == 3'b000)
               nxt_st = S_LOST;
         end
         S_OBSTACLE: begin
            if (!all_clear) begin
               tmr_nxt = 32'd0;
            end else if (tmr >= CLEAR_CYC - 32'd1) begin
               nxt_st  = S_FOLLOW;
               tmr_nxt = 32'd0;
            end else begin
               tmr_nxt = tmr + 32'd1;
            end
         end
         S_LOST: begin
            // obstacle beats line-found beats timeout
            if (too_near) begin
               nxt_st  = S_OBSTACLE;
               tmr_nxt = 32'd0;
            end else if (trk != 3'b000) begin
               nxt_st  = S_FOLLOW;
               tmr_nxt = 32'd0;
            end else if (tmr >= LOST_CYC - 32'd1) begin
               nxt_st  = S_HALT;
               tmr_nxt = 32'd0;
            end else begin
               tmr_nxt = tmr + 32'd1;
            end
         end
         S_HALT: begin
            tmr_nxt = 32'd0;
         end
         default: begin
            nxt_st  = S_IDLE;
            tmr_nxt = 32'd0;
         end
      endcase
   end

   // mode is derived from the next state so mode and state always move
   // together on the same edge.
   always_comb begin
      mode_nxt = MODE_STOP;
      case (nxt_st)
         S_FOLLOW: mode_nxt = map_mode;
         S_LOST:   mode_nxt = lost_mode;
         default:  mode_nxt = MODE_STOP;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_st   <= S_IDLE;
         tmr      <= 32'd0;
         mode     <= MODE_STOP;
         obstacle <= 1'b0;
         last_dir <= MODE_FWD;
      end else begin
         cur_st   <= nxt_st;
         tmr      <= tmr_nxt;
         mode     <= mode_nxt;
         obstacle <= (nxt_st == S_OBSTACLE);
         if (cur_st == S_FOLLOW && trk != 3'b000)
            last_dir <= map_mode;
      end
   end

   assign state = cur_st;

endmodule
